// File: rtl/rf_dump_ctrl_pkg.sv
// Shared definitions for the register-file dump controller: FSM state encoding
// and default geometry of the register file being walked.
package rf_dump_ctrl_pkg;

   localparam int NUM_REGS_DEF = 4;
   localparam int ADDR_W_DEF   = 2;
   localparam int DATA_W_DEF   = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_SEND  = 3'd2,
      ST_CSUM  = 3'd3,
      ST_FIN   = 3'd4
   } state_e;

endpackage

// File: rtl/rf_dump_ctrl_if.sv
// Bundle of the dump request, register-file read port and byte-stream
// handshake signals; master is the controller, slave is its environment.
interface rf_dump_ctrl_if
   import rf_dump_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   logic              START;
   logic [ADDR_W-1:0] N1;
   logic [DATA_W-1:0] Q1;
   logic [DATA_W-1:0] OUT_DATA;
   logic              OUT_VALID;
   logic              OUT_READY;
   logic              BUSY;
   logic              DONE;

   modport master (
      input  START, Q1, OUT_READY,
      output N1, OUT_DATA, OUT_VALID, BUSY, DONE
   );

   modport slave (
      output START, Q1, OUT_READY,
      input  N1, OUT_DATA, OUT_VALID, BUSY, DONE
   );

endinterface

// File: rtl/rf_dump_xsum.sv
// Running XOR accumulator over the bytes of one dump; clear wins over enable.
// Only instantiated when RF_DUMP_CHECKSUM_EN is defined.
module rf_dump_xsum #(
   parameter int DATA_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clr_i,
   input  logic              en_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] sum_o
);

   logic [DATA_W-1:0] sum_d;
   logic [DATA_W-1:0] sum_q;

   // next accumulator value
   always_comb begin
      sum_d = sum_q;
      if (clr_i) begin
         sum_d = {DATA_W{1'b0}};
      end else if (en_i) begin
         sum_d = sum_q ^ data_i;
      end else begin
         sum_d = sum_q;
      end
   end

   // accumulator register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sum_q <= {DATA_W{1'b0}};
      end else begin
         sum_q <= sum_d;
      end
   end

   assign sum_o = sum_q;

endmodule

// File: rtl/rf_dump_ctrl.sv
// Walks NUM_REGS register-file entries and streams them out under a
// valid/ready handshake. Define RF_DUMP_CHECKSUM_EN to append an XOR checksum byte.
module rf_dump_ctrl
   import rf_dump_ctrl_pkg::*;
#(
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF
) (
   input  logic           CLK,
   input  logic           RESET,
   rf_dump_ctrl_if.master bus
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   state_e            state_q;
   logic [ADDR_W-1:0] index_q;
   logic [DATA_W-1:0] out_data_q;
   logic              out_valid_q;
   logic              busy_q;
   logic              done_q;
   logic              hs_s;

   assign hs_s = out_valid_q && bus.OUT_READY;

`ifdef RF_DUMP_CHECKSUM_EN
   logic [DATA_W-1:0] xsum_s;
   logic              xsum_clr_s;
   logic              xsum_en_s;

   assign xsum_clr_s = ((state_q == ST_IDLE) || (state_q == ST_FIN)) && bus.START;
   assign xsum_en_s  = (state_q == ST_SEND) && hs_s;

   rf_dump_xsum #(.DATA_W(DATA_W)) u_xsum (
      .clk_i  (CLK),
      .rst_i  (RESET),
      .clr_i  (xsum_clr_s),
      .en_i   (xsum_en_s),
      .data_i (out_data_q),
      .sum_o  (xsum_s)
   );
`endif

   // dump sequencer with registered outputs
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= ST_IDLE;
         index_q     <= {ADDR_W{1'b0}};
         out_data_q  <= {DATA_W{1'b0}};
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            // FIN accepts a held START directly so back-to-back dumps lose no cycle
            ST_IDLE, ST_FIN: begin
               index_q     <= {ADDR_W{1'b0}};
               out_valid_q <= 1'b0;
               if (bus.START) begin
                  state_q <= ST_FETCH;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            ST_FETCH: begin
               out_data_q  <= bus.Q1;
               out_valid_q <= 1'b1;
               state_q     <= ST_SEND;
            end
            ST_SEND: begin
               if (hs_s) begin
                  if (index_q != LAST_IDX) begin
                     index_q     <= index_q + ADDR_W'(1'b1);
                     out_valid_q <= 1'b0;
                     state_q     <= ST_FETCH;
                  end else begin
`ifdef RF_DUMP_CHECKSUM_EN
                     // accumulator has not yet absorbed the byte just accepted
                     out_data_q <= xsum_s ^ out_data_q;
                     state_q    <= ST_CSUM;
`else
                     out_valid_q <= 1'b0;
                     busy_q      <= 1'b0;
                     done_q      <= 1'b1;
                     state_q     <= ST_FIN;
`endif
                  end
               end else begin
                  state_q <= ST_SEND;
               end
            end
`ifdef RF_DUMP_CHECKSUM_EN
            ST_CSUM: begin
               if (hs_s) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  state_q     <= ST_FIN;
               end else begin
                  state_q <= ST_CSUM;
               end
            end
`endif
            default: begin
               state_q     <= ST_IDLE;
               index_q     <= {ADDR_W{1'b0}};
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.N1        = index_q;
   assign bus.OUT_DATA  = out_data_q;
   assign bus.OUT_VALID = out_valid_q;
   assign bus.BUSY      = busy_q;
   assign bus.DONE      = done_q;

endmodule

// File: tb/tb_rf_dump_ctrl.sv
// Directed bench for rf_dump_ctrl; honours RF_DUMP_CHECKSUM_EN for the
// expected byte count and dump period.
module tb_rf_dump_ctrl;

   localparam int NUM_REGS = 4;
   localparam int ADDR_W   = 2;
   localparam int DATA_W   = 8;
`ifdef RF_DUMP_CHECKSUM_EN
   localparam int NB  = 5;
   localparam int GAP = 10;
`else
   localparam int NB  = 4;
   localparam int GAP = 9;
`endif

   logic CLK = 1'b0;
   logic RESET;

   rf_dump_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   rf_dump_ctrl #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus.master)
   );

   always #5 CLK = ~CLK;

   logic [7:0] regs [NUM_REGS];
   logic [7:0] exp_bytes [5];
   assign bus.Q1 = regs[bus.N1];

   int err_cnt = 0;
   int chk_cnt = 0;
   int done_cnt = 0;
   int cyc = 0;
   logic [7:0] got_q [$];
   int done_cyc [$];

   // record accepted bytes and DONE pulses
   always @(posedge CLK) begin
      cyc <= cyc + 1;
      if (bus.OUT_VALID && bus.OUT_READY && !RESET) got_q.push_back(bus.OUT_DATA);
      if (bus.DONE) begin
         done_cnt <= done_cnt + 1;
         done_cyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      chk_cnt++;
      if (obs !== exp_v) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic pulse_start();
      bus.START = 1'b1;
      tick(1);
      bus.START = 1'b0;
   endtask

   task automatic wait_byte(input int idx);
      bit ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (bus.OUT_VALID && (bus.N1 == idx)) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
      check("wait_byte", 32'(ok), 32'd1);
   endtask

   task automatic check_dump(input string tag, input int b, input int d);
      check({tag, "_len"}, 32'(got_q.size() - b), 32'(NB));
      for (int i = 0; i < NB; i++) begin
         if (b + i < got_q.size()) check($sformatf("%s_b%0d", tag, i), 32'(got_q[b + i]), 32'(exp_bytes[i]));
      end
      check({tag, "_done"}, 32'(done_cnt - d), 32'd1);
   endtask

   initial begin
      int b;
      int d;
      bit ok;
      regs[0] = 8'h11; regs[1] = 8'h22; regs[2] = 8'h33; regs[3] = 8'h44;
      exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22; exp_bytes[2] = 8'h33;
      exp_bytes[3] = 8'h44; exp_bytes[4] = 8'h44;
      RESET = 1'b1;
      bus.START = 1'b1;
      bus.OUT_READY = 1'b1;
      tick(3);
      check("rst_valid", 32'(bus.OUT_VALID), 32'd0);
      check("rst_busy",  32'(bus.BUSY), 32'd0);
      check("rst_done",  32'(bus.DONE), 32'd0);
      check("rst_n1",    32'(bus.N1), 32'd0);
      check("rst_data",  32'(bus.OUT_DATA), 32'd0);
      bus.START = 1'b0;
      RESET = 1'b0;
      tick(2);

      // basic dump and first-byte latency
      b = got_q.size(); d = done_cnt;
      bus.START = 1'b1;
      tick(1);
      bus.START = 1'b0;
      check("lat_fetch_busy",  32'(bus.BUSY), 32'd1);
      check("lat_fetch_valid", 32'(bus.OUT_VALID), 32'd0);
      check("lat_fetch_n1",    32'(bus.N1), 32'd0);
      tick(1);
      check("lat_send_valid", 32'(bus.OUT_VALID), 32'd1);
      check("lat_send_data",  32'(bus.OUT_DATA), 32'h11);
      tick(20);
      check_dump("basic", b, d);
      check("idle_busy", 32'(bus.BUSY), 32'd0);
      check("idle_n1",   32'(bus.N1), 32'd0);

      // stall on byte 1 while the register is rewritten
      b = got_q.size(); d = done_cnt;
      pulse_start();
      wait_byte(1);
      bus.OUT_READY = 1'b0;
      regs[1] = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         check("stall_valid", 32'(bus.OUT_VALID), 32'd1);
         check("stall_data",  32'(bus.OUT_DATA), 32'h22);
      end
      bus.OUT_READY = 1'b1;
      tick(20);
      check_dump("stall", b, d);
      regs[1] = 8'h22;

      // START during a dump is ignored
      b = got_q.size(); d = done_cnt;
      pulse_start();
      wait_byte(1);
      pulse_start();
      tick(20);
      check_dump("restart", b, d);

      // reset mid-dump
      b = got_q.size(); d = done_cnt;
      pulse_start();
      wait_byte(1);
      bus.OUT_READY = 1'b0;
      RESET = 1'b1;
      bus.START = 1'b1;
      tick(1);
      RESET = 1'b0;
      bus.START = 1'b0;
      bus.OUT_READY = 1'b1;
      check("mid_rst_valid", 32'(bus.OUT_VALID), 32'd0);
      check("mid_rst_busy",  32'(bus.BUSY), 32'd0);
      check("mid_rst_n1",    32'(bus.N1), 32'd0);
      tick(15);
      check("mid_rst_len",  32'(got_q.size() - b), 32'd1);
      if (got_q.size() > b) check("mid_rst_b0", 32'(got_q[b]), 32'h11);
      check("mid_rst_done", 32'(done_cnt - d), 32'd0);
      b = got_q.size(); d = done_cnt;
      pulse_start();
      tick(20);
      check_dump("after_rst", b, d);

      // START held high: back-to-back dumps
      b = got_q.size(); d = done_cnt;
      bus.START = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick(1);
         if (done_cnt - d >= 2) begin
            ok = 1'b1;
            break;
         end
      end
      bus.START = 1'b0;
      check("held_two_dumps", 32'(ok), 32'd1);
      check("held_len", 32'(got_q.size() - b), 32'(2 * NB));
      if (ok) check("held_gap", 32'(done_cyc[d + 1] - done_cyc[d]), 32'(GAP));
      for (int i = 0; i < 2 * NB; i++) begin
         if (b + i < got_q.size()) check($sformatf("held_b%0d", i), 32'(got_q[b + i]), 32'(exp_bytes[i % NB]));
      end
      tick(25);
      check("end_busy", 32'(bus.BUSY), 32'd0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/rf_dump_ctrl.md
RF_DUMP_CTRL -- requirements
Module: rf_dump_ctrl

Interface
REQ-001 Parameter NUM_REGS, default 4: number of register-file entries walked per dump.
REQ-002 Parameter ADDR_W, default 2: register index width, equal to clog2(NUM_REGS).
REQ-003 Parameter DATA_W, default 8: register data width.
REQ-004 CLK  input  1: single clock; all state SHALL update on its rising edge.
REQ-005 RESET  input  1: synchronous, active-high reset, sampled on the rising edge of CLK.
REQ-006 START  input  1: dump request, level-sampled.
REQ-007 N1  output  ADDR_W: read index driven to the register-file read port.
REQ-008 Q1  input  DATA_W: combinational read data returned for N1.
REQ-009 OUT_DATA  output  DATA_W: byte presented to the consumer.
REQ-010 OUT_VALID  output  1: OUT_DATA holds a valid byte.
REQ-011 OUT_READY  input  1: consumer accepts the byte.
REQ-012 BUSY  output  1: dump in progress.
REQ-013 DONE  output  1: one-cycle pulse after the last byte is accepted.

Function
REQ-014 FSM states SHALL be IDLE, FETCH, SEND, CSUM, FIN.
REQ-015 IDLE: START=1 -> FETCH with the index counter cleared to 0; otherwise remain in IDLE.
REQ-016 FETCH: N1 = index; Q1 captured into a holding register; -> SEND next cycle.
REQ-017 SEND: OUT_VALID=1 and OUT_DATA = held byte, stable until OUT_VALID && OUT_READY.
REQ-018 On SEND handshake with index < NUM_REGS-1: index increments -> FETCH.
REQ-019 On SEND handshake with index = NUM_REGS-1: -> CSUM if the checksum is enabled, else -> FIN.
REQ-020 FIN: DONE=1 for exactly one cycle -> IDLE.
REQ-021 Latency: START sampled in IDLE -> first OUT_VALID exactly 2 cycles later, given no stall.
REQ-022 The index SHALL NOT wrap mid-dump; it stops at NUM_REGS-1.
REQ-023 Register-file changes during a SEND stall SHALL NOT alter OUT_DATA.
REQ-024 START while BUSY=1 SHALL be ignored and not queued.
REQ-025 START held high through FIN SHALL begin a new dump on the cycle after FIN.
REQ-026 BUSY SHALL be 1 in FETCH, SEND and CSUM, and 0 in IDLE and FIN.
REQ-027 N1 SHALL equal the index in every state and 0 in IDLE.
REQ-028 OUT_READY high while OUT_VALID=0 SHALL have no effect.

Reset
REQ-029 RESET=1 at a clock edge SHALL force IDLE, index=0, N1=0, OUT_VALID=0, OUT_DATA=0, BUSY=0, DONE=0, and checksum=0.
REQ-030 Reset mid-dump SHALL abandon the dump, with no DONE pulse and no further bytes.
REQ-031 RESET SHALL take priority over START and OUT_READY in the same cycle.

Configuration
REQ-032 Macro RF_DUMP_CHECKSUM_EN, when defined: running XOR of all sent register bytes; CSUM state presents it as a final byte under the same handshake, then -> FIN.
REQ-033 Without RF_DUMP_CHECKSUM_EN: CSUM state and accumulator absent; exactly NUM_REGS bytes per dump.

Structure
REQ-034 Shared package SHALL hold the FSM state encoding and the default NUM_REGS/ADDR_W/DATA_W constants.
REQ-035 Sub-module rf_dump_xsum (XOR accumulator with clear/enable) SHALL be instantiated only under RF_DUMP_CHECKSUM_EN.

Verification
REQ-036 Regs {0x11,0x22,0x33,0x44}, START pulse, OUT_READY=1 -> bytes 0x11,0x22,0x33,0x44 on consecutive SEND cycles, then one DONE pulse.
REQ-037 Same data, checksum enabled -> fifth byte 0x44 (0x11^0x22^0x33^0x44), then DONE.
REQ-038 OUT_READY=0 for 5 cycles during byte 1 while reg1 is rewritten to 0xFF -> OUT_DATA holds 0x22, and no byte is lost or duplicated.
REQ-039 START pulsed again during SEND of byte 2 -> ignored, exactly 4 (or 5) bytes, one DONE.
REQ-040 RESET=1 during SEND of byte 2 -> next cycle OUT_VALID=0, BUSY=0, N1=0; no DONE pulse; a new START gives a full dump starting at 0x11.
REQ-041 START held high continuously -> back-to-back dumps separated by the FIN cycle, each with a DONE pulse.
